// File: rtl/fast_scan_controller.sv
// Purpose: steps buffer_loader over every interior pixel of a frame in raster order and presents each loaded ring to the FAST score stage.
// Latency: 1 ISSUE cycle + loader time + 1 PRESENT cycle (when ready) + 1 ADVANCE cycle per candidate.
// Backpressure: cand_valid and the coordinates are held in PRESENT while cand_ready is low, with no watchdog there.
module fast_scan_controller #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int BORDER  = 3,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              frame_start,
    input  logic              abort,
    output logic              loader_start,
    input  logic              loader_done,
    output logic signed [8:0] curr_x,
    output logic signed [8:0] curr_y,
    output logic              cand_valid,
    input  logic              cand_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err,
    output logic [16:0]       cand_count
);

    // Reject geometries that leave no interior pixel or overflow the 9-bit signed coordinates.
    generate
        if (IMG_W <= 2 * BORDER || IMG_H <= 2 * BORDER) begin : g_bad_dims
            $error("fast_scan_controller: image must be larger than 2*BORDER in both dimensions");
        end
        if (IMG_W > 256 || IMG_H > 256) begin : g_bad_size
            $error("fast_scan_controller: IMG_W and IMG_H must be <= 256");
        end
        if (BORDER < 3) begin : g_bad_border
            $error("fast_scan_controller: BORDER must cover the FAST circle radius of 3");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("fast_scan_controller: TIMEOUT must be at least 1");
        end
    endgenerate

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_ADVANCE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic signed [8:0] X_FIRST = 9'(BORDER);
    localparam logic signed [8:0] Y_FIRST = 9'(BORDER);
    localparam logic signed [8:0] X_LAST  = 9'(IMG_W - 1 - BORDER);
    localparam logic signed [8:0] Y_LAST  = 9'(IMG_H - 1 - BORDER);

    localparam int             WDW      = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic signed [8:0] x_q, x_d;
    logic signed [8:0] y_q, y_d;
    logic [WDW-1:0]    wdog_q, wdog_d;
    logic [16:0]       cnt_q, cnt_d;
    logic              terr_q, terr_d;

    // Next-state logic for the scan sequencer; abort overrides everything and freezes the datapath.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        wdog_d  = wdog_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_ISSUE;
                    x_d     = X_FIRST;
                    y_d     = Y_FIRST;
                    cnt_d   = '0;
                    terr_d  = 1'b0;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (loader_done) begin
                    state_d = S_PRESENT;
                end else if (wdog_q == WD_LIMIT) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            S_PRESENT: begin
                if (cand_ready) begin
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 17'd1;
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (x_q == X_LAST) begin
                    if (y_q == Y_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        x_d     = X_FIRST;
                        y_d     = y_q + 9'sd1;
                        state_d = S_ISSUE;
                    end
                end else begin
                    x_d     = x_q + 9'sd1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
            x_d     = x_q;
            y_d     = y_q;
            wdog_d  = wdog_q;
            cnt_d   = cnt_q;
            terr_d  = terr_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            x_q     <= X_FIRST;
            y_q     <= Y_FIRST;
            wdog_q  <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wdog_q  <= wdog_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    // Moore outputs decoded from the registered state.
    assign loader_start = (state_q == S_ISSUE);
    assign cand_valid   = (state_q == S_PRESENT);
    assign busy         = (state_q != S_IDLE);
    assign frame_done   = (state_q == S_DONE);
    assign timeout_err  = terr_q;
    assign cand_count   = cnt_q;
    assign curr_x       = x_q;
    assign curr_y       = y_q;

endmodule

// File: tb/tb_fast_scan_controller.sv
module tb_fast_scan_controller;

    logic              clk;
    logic              n_rst;
    logic              frame_start;
    logic              abort;
    logic              loader_start;
    logic              loader_done;
    logic signed [8:0] curr_x;
    logic signed [8:0] curr_y;
    logic              cand_valid;
    logic              cand_ready;
    logic              busy;
    logic              frame_done;
    logic              timeout_err;
    logic [16:0]       cand_count;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    // behavioural loader: done pulses ld_lat cycles after start; 0 means never
    int   ld_lat = 34;
    int   ld_cnt = 0;
    logic mdl_done;
    logic spur_done;
    assign loader_done = mdl_done | spur_done;

    typedef struct {
        int lat;
        int stall;
        int inj;
        int ex;
        int ey;
        int ecnt;
    } vec_t;
    vec_t tbl[8];

    fast_scan_controller #(.IMG_W(10), .IMG_H(8), .BORDER(3), .TIMEOUT(64)) dut (
        .clk(clk), .n_rst(n_rst), .frame_start(frame_start), .abort(abort),
        .loader_start(loader_start), .loader_done(loader_done),
        .curr_x(curr_x), .curr_y(curr_y), .cand_valid(cand_valid), .cand_ready(cand_ready),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err), .cand_count(cand_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        mdl_done = 1'b0;
        forever begin
            @(negedge clk);
            if (loader_start) begin
                ld_cnt   = ld_lat;
                mdl_done = 1'b0;
            end else if (ld_cnt > 0) begin
                ld_cnt   = ld_cnt - 1;
                mdl_done = (ld_cnt == 0);
            end else begin
                mdl_done = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    // waits for the loader start of one candidate and then for cand_valid; returns at the first PRESENT negedge
    task automatic present_cand(input int lat, input int ex, input int ey);
        int n;
        bit seen;
        ld_lat = lat;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (loader_start) seen = 1;
        end
        chk("loader_start_seen", int'(seen), 1);
        n = 0;
        seen = 0;
        for (int i = 0; i < lat + 10 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (cand_valid) seen = 1;
        end
        chk("cand_valid_seen", int'(seen), 1);
        chk("start_to_valid_cycles", n, lat + 1);
        chk("cand_x", int'(curr_x), ex);
        chk("cand_y", int'(curr_y), ey);
    endtask

    task automatic run_cand(input vec_t v);
        present_cand(v.lat, v.ex, v.ey);
        if (v.inj != 0) begin
            frame_start = 1'b1;
            spur_done   = 1'b1;
        end
        cand_ready = (v.stall == 0);
        for (int i = 1; i <= v.stall; i++) begin
            @(negedge clk);
            frame_start = 1'b0;
            spur_done   = 1'b0;
            chk("hold_valid", int'(cand_valid), 1);
            chk("hold_x", int'(curr_x), v.ex);
            chk("hold_y", int'(curr_y), v.ey);
            chk("hold_no_start", int'(loader_start), 0);
            if (i == v.stall) cand_ready = 1'b1;
        end
        @(negedge clk);
        frame_start = 1'b0;
        spur_done   = 1'b0;
        cand_ready  = 1'b0;
        chk("advance_valid_low", int'(cand_valid), 0);
        chk("cand_count", int'(cand_count), v.ecnt);
    endtask

    initial begin
        int fd_before;
        n_rst       = 1'b0;
        frame_start = 1'b0;
        abort       = 1'b0;
        cand_ready  = 1'b0;
        spur_done   = 1'b0;

        tbl[0] = '{lat: 34, stall: 0, inj: 0, ex: 3, ey: 3, ecnt: 1};
        tbl[1] = '{lat: 34, stall: 5, inj: 0, ex: 4, ey: 3, ecnt: 2};
        tbl[2] = '{lat: 34, stall: 1, inj: 1, ex: 5, ey: 3, ecnt: 3};
        tbl[3] = '{lat: 34, stall: 0, inj: 0, ex: 6, ey: 3, ecnt: 4};
        tbl[4] = '{lat: 34, stall: 2, inj: 0, ex: 3, ey: 4, ecnt: 5};
        tbl[5] = '{lat: 34, stall: 0, inj: 1, ex: 4, ey: 4, ecnt: 6};
        tbl[6] = '{lat: 34, stall: 0, inj: 0, ex: 5, ey: 4, ecnt: 7};
        tbl[7] = '{lat: 34, stall: 0, inj: 0, ex: 6, ey: 4, ecnt: 8};

        // reset state
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_x", int'(curr_x), 3);
        chk("rst_y", int'(curr_y), 3);
        chk("rst_outputs", {loader_start, cand_valid, frame_done, timeout_err}, 0);
        chk("rst_count", int'(cand_count), 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // full frame with stalls, spurious done and frame_start while busy
        start_frame();
        for (int i = 0; i < 8; i++) run_cand(tbl[i]);
        repeat (4) @(negedge clk);
        chk("frame_done_pulses", fd_cnt, 1);
        chk("frame_count", int'(cand_count), 8);
        chk("frame_end_busy", int'(busy), 0);
        chk("frame_end_x", int'(curr_x), 6);
        chk("frame_end_y", int'(curr_y), 4);

        // abort during PRESENT of the third candidate
        fd_before = fd_cnt;
        start_frame();
        run_cand('{lat: 2, stall: 0, inj: 0, ex: 3, ey: 3, ecnt: 1});
        run_cand('{lat: 2, stall: 0, inj: 0, ex: 4, ey: 3, ecnt: 2});
        present_cand(2, 5, 3);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(cand_valid), 0);
        chk("abort_count", int'(cand_count), 2);
        repeat (5) @(negedge clk);
        chk("abort_no_start", int'(loader_start), 0);
        chk("abort_no_frame_done", fd_cnt, fd_before);

        // loader never completes
        fd_before = fd_cnt;
        ld_lat = 0;
        start_frame();
        @(negedge clk);
        chk("to_issue", int'(loader_start), 1);
        repeat (64) @(negedge clk);
        chk("to_pre_busy", int'(busy), 1);
        chk("to_pre_err", int'(timeout_err), 0);
        @(negedge clk);
        chk("to_err", int'(timeout_err), 1);
        chk("to_idle", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("to_sticky", int'(timeout_err), 1);
        chk("to_no_frame_done", fd_cnt, fd_before);
        start_frame();
        @(negedge clk);
        chk("to_cleared", int'(timeout_err), 0);
        chk("to_restart", int'(loader_start), 1);

        // reset while waiting on the loader
        repeat (5) @(negedge clk);
        chk("wait_busy", int'(busy), 1);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_outputs", {loader_start, cand_valid, frame_done, timeout_err}, 0);
        chk("mid_rst_xy", {23'd0, curr_x}, 3);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
